// File: rtl/iterative_arith_unit.sv
// Multi-cycle unsigned ADD/SUB/MUL/DIV unit with a start/busy/valid handshake.
// ADD/SUB/MUL and divide-by-zero answer in one cycle; DIV runs a WIDTH-step restoring divider.
module iterative_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALU_FUN,
  input  logic             Arith_Enable,
  output logic             Busy,
  output logic             Arith_Valid,
  output logic [WIDTH-1:0] Arith_OUT,
  output logic [WIDTH-1:0] Arith_OUT_HI,
  output logic             Carry_OUT,
  output logic             Div_Zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_MUL = 2'b10;
  localparam logic [1:0] FUN_DIV = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } state_t;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor when it fits and record the quotient bit.
  // Returned as {remainder[WIDTH:0], quotient/dividend shift register[WIDTH-1:0]}.
  function automatic logic [2*WIDTH:0] div_step(
    input logic [WIDTH:0]   rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (shifted >= {1'b0, dvs}) begin
      div_step = {trial, quo[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {shifted, quo[WIDTH-2:0], 1'b0};
    end
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;
  logic             carry_q, carry_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic [2*WIDTH-1:0] prod_w;
  logic [2*WIDTH:0]   step_w;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign dif_w  = {1'b0, A} - {1'b0, B};
  assign prod_w = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  assign step_w = div_step(rem_q, quo_q, dvs_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    valid_d  = 1'b0;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    carry_d  = carry_q;
    dz_d     = dz_q;

    case (state_q)
      IDLE: begin
        if (Arith_Enable) begin
          case (ALU_FUN)
            FUN_ADD: begin
              out_d    = sum_w[WIDTH-1:0];
              out_hi_d = '0;
              carry_d  = sum_w[WIDTH];
              dz_d     = 1'b0;
              valid_d  = 1'b1;
            end
            FUN_SUB: begin
              out_d    = dif_w[WIDTH-1:0];
              out_hi_d = '0;
              carry_d  = dif_w[WIDTH];
              dz_d     = 1'b0;
              valid_d  = 1'b1;
            end
            FUN_MUL: begin
              out_d    = prod_w[WIDTH-1:0];
              out_hi_d = prod_w[2*WIDTH-1:WIDTH];
              carry_d  = 1'b0;
              dz_d     = 1'b0;
              valid_d  = 1'b1;
            end
            FUN_DIV: begin
              if (B == '0) begin
                out_d    = '1;
                out_hi_d = A;
                carry_d  = 1'b0;
                dz_d     = 1'b1;
                valid_d  = 1'b1;
              end else begin
                state_d = DIV_RUN;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = A;
                dvs_d   = B;
              end
            end
            default: ;
          endcase
        end
      end

      DIV_RUN: begin
        rem_d = step_w[2*WIDTH:WIDTH];
        quo_d = step_w[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d  = IDLE;
          out_d    = step_w[WIDTH-1:0];
          out_hi_d = step_w[2*WIDTH-1:WIDTH];
          carry_d  = 1'b0;
          dz_d     = 1'b0;
          valid_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      carry_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      carry_q  <= carry_d;
      dz_q     <= dz_d;
    end
  end

  // Divider datapath: only meaningful while in DIV_RUN, reloaded on every accept.
  always_ff @(posedge CLK) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign Busy         = (state_q == DIV_RUN);
  assign Arith_Valid  = valid_q;
  assign Arith_OUT    = out_q;
  assign Arith_OUT_HI = out_hi_q;
  assign Carry_OUT    = carry_q;
  assign Div_Zero     = dz_q;

endmodule

// File: doc/iterative_arith_unit.md
# iterative_arith_unit

Parametrised, multi-cycle successor to the single-cycle arithmetic unit in the ALU hierarchy. It performs unsigned ADD, SUB, MUL and DIV on WIDTH-bit operands. ADD, SUB and MUL return a full-width result: carry/borrow, or the high product word. DIV uses a restoring radix-2 divider that returns both quotient and remainder. A start/busy/valid handshake lets the ALU top issue one operation at a time and sample a single-cycle result strobe.

## Interface
- WIDTH, 8, operand and result word width (≥2)
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- A  input  WIDTH  operand A (dividend for DIV)
- B  input  WIDTH  operand B (divisor for DIV)
- ALU_FUN  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- Arith_Enable  input  1  start request; accepted only when Busy=0
- Busy  output  1  divider iterating; new requests ignored
- Arith_Valid  output  1  one-cycle strobe: result outputs updated this cycle
- Arith_OUT  output  WIDTH  sum / difference / product low word / quotient
- Arith_OUT_HI  output  WIDTH  product high word (MUL) / remainder (DIV) / 0 (ADD, SUB)
- Carry_OUT  output  1  ADD carry-out; SUB borrow (1 when A<B); 0 for MUL and DIV
- Div_Zero  output  1  last DIV had B=0; 0 after any other op

## Operation
- FSM states: IDLE, DIV_RUN.
- Accept: Arith_Enable=1 and Busy=0 at a rising edge. A, B and ALU_FUN are captured at that edge only. Later operand changes have no effect.
- ADD, SUB, MUL from IDLE: one registered result. FSM stays in IDLE.
- ADD: {Carry_OUT, Arith_OUT} = A+B.
- SUB: Arith_OUT = (A−B) mod 2^WIDTH; Carry_OUT = borrow.
- MUL: {Arith_OUT_HI, Arith_OUT} = A×B, full 2·WIDTH-bit product.
- DIV with B≠0: IDLE→DIV_RUN. Runs a WIDTH-iteration restoring division, one quotient bit per cycle, MSB first, with remainder register width WIDTH+1. Last iteration → IDLE.
- DIV with B=0: no iteration, single-cycle result.
  - Arith_OUT = all ones.
  - Arith_OUT_HI = A.
  - Div_Zero = 1.
  - FSM stays IDLE.
- Result outputs hold their last values until the next Arith_Valid, then update together.
- Arith_Enable while Busy=1: ignored, not queued.
- Arith_Enable=0: no state change. Outputs hold. Arith_Valid=0.

## Timing
- Reset, applied at any edge including mid-division:
  - next cycle FSM=IDLE
  - Busy=0, Arith_Valid=0
  - Arith_OUT=0, Arith_OUT_HI=0, Carry_OUT=0, Div_Zero=0
  - in-flight division discarded, no Valid produced
- RST has priority over Arith_Enable.
- ADD/SUB/MUL and DIV-by-zero:
  - latency 1: accepted at edge k → results and Arith_Valid=1 in cycle after edge k
  - Busy stays 0
  - back-to-back accepts every cycle are allowed
- DIV, B≠0, accepted at edge k:
  - Busy=1 after edges k … k+WIDTH−1
  - iterations occur at edges k+1 … k+WIDTH
  - after edge k+WIDTH: Busy=0, Arith_Valid=1, quotient/remainder visible
  - latency WIDTH+1 edges
- In the cycle where Arith_Valid=1 from a DIV, Busy=0. An Arith_Enable in that cycle is accepted (zero bubble).
- Arith_Valid is never high for two consecutive cycles from one operation. It is high in consecutive cycles only for back-to-back accepted operations.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
All cases use WIDTH=8.
- Reset: assert RST 2 cycles during a DIV in flight → all outputs 0, Busy 0, no Arith_Valid afterwards. Then ADD 3+4 → Arith_OUT=7 with Valid one cycle after accept.
- ADD/SUB: ADD 200+100 → Arith_OUT=44, Carry_OUT=1. Next cycle SUB 5−7 → Arith_OUT=254, Carry_OUT=1. Then SUB 7−5 → Arith_OUT=2, Carry_OUT=0. Valid high three consecutive cycles.
- MUL: 200×3 → Arith_OUT=0x58, Arith_OUT_HI=0x02, Carry_OUT=0, latency 1. Then 255×255 → 0x01 / 0xFE.
- DIV: 200÷7 → Busy high 8 cycles, then Arith_OUT=28, Arith_OUT_HI=4, Valid 9 edges after accept. Pulse Arith_Enable (ADD) mid-division → ignored, no extra Valid. Issue ADD in the Valid cycle → accepted.
- Divide by zero: 123÷0 → next cycle Arith_OUT=0xFF, Arith_OUT_HI=123, Div_Zero=1, Busy never set. Following ADD clears Div_Zero.
- Random regression: 10k random ops against a reference model, checking result, latency, Busy and Valid behaviour, with random RST injection.
